// File: rtl/message_unpad.sv
// message_unpad: collects padded 512-bit blocks, validates padding and the length field, then emits the message as 32-bit words.
// Latency: first word_valid appears 2 cycles after the final block is accepted.
// Backpressure: blk_ready is high only while collecting; an emitted word holds steady while word_ready is low.
module message_unpad #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [511:0]     blk_data,
  input  logic             blk_valid,
  input  logic             blk_last,
  output logic             blk_ready,
  output logic [31:0]      word_data,
  output logic [5:0]       word_nbits,
  output logic             word_valid,
  output logic             word_last,
  input  logic             word_ready,
  output logic [LEN_W-1:0] msg_len,
  output logic             done,
  output logic             err
);

  localparam int MAX_BLK = ((2 ** LEN_W) - 1 + 65 + 511) / 512;
  localparam int BUF_W   = MAX_BLK * 512;
  localparam int NWORD   = BUF_W / 32;
  localparam int CNT_W   = $clog2(MAX_BLK + 1);
  localparam int WIDX_W  = $clog2(NWORD);
  localparam int IDX_W   = $clog2(BUF_W);

  typedef enum logic [2:0] {S_COLLECT, S_CHECK, S_EMIT, S_DONE, S_ERR} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          blk_cnt_q, blk_cnt_d;
  // Slot s lives at blk_q[MAX_BLK-1-s] so the flattened buffer holds message bit p at index BUF_W-1-p.
  logic [MAX_BLK-1:0][511:0] blk_q, blk_d;
  logic [WIDX_W-1:0]         word_idx_q, word_idx_d;
  logic [LEN_W-1:0]          msg_len_q, msg_len_d;

  logic [BUF_W-1:0]          flat;
  logic [NWORD-1:0][31:0]    words;
  assign flat  = blk_q;
  assign words = blk_q;

  logic [63:0]      len_field;
  logic [LEN_W-1:0] chk_len;
  int               req_blk;
  logic [BUF_W-1:0] zero_mask;
  logic             chk_pass;

  // Decode the length field of the final block and validate block count, pad bit and zero fill.
  always_comb begin
    len_field = '0;
    for (int k = 0; k < MAX_BLK; k++) begin
      if (blk_cnt_q == CNT_W'(k + 1)) len_field = blk_q[MAX_BLK-1-k][63:0];
    end
    chk_len   = len_field[LEN_W-1:0];
    req_blk   = (int'(chk_len) + 576) >> 9;
    // Message positions L+1 .. req_blk*512-65 must all be zero.
    zero_mask = ({BUF_W{1'b1}} >> (int'(chk_len) + 1)) &
                ({BUF_W{1'b1}} << (BUF_W + 64 - 512 * req_blk));
    chk_pass  = (len_field[63:LEN_W] == '0) &&
                (int'(blk_cnt_q) == req_blk) &&
                flat[IDX_W'(BUF_W - 1) - IDX_W'(chk_len)] &&
                ((flat & zero_mask) == '0);
  end

  logic [LEN_W:0]  n_words;
  logic [LEN_W:0]  rem_bits;
  logic            last_word;
  logic [5:0]      cur_nbits;
  logic [31:0]     cur_word;

  // Current output word: slice, valid-bit count and trailing-bit mask.
  always_comb begin
    n_words   = ({1'b0, msg_len_q} + (LEN_W+1)'(31)) >> 5;
    rem_bits  = {1'b0, msg_len_q} - ((LEN_W+1)'(word_idx_q) << 5);
    last_word = ((LEN_W+1)'(word_idx_q) == (n_words - (LEN_W+1)'(1)));
    cur_nbits = last_word ? rem_bits[5:0] : 6'd32;
    cur_word  = words[WIDX_W'(NWORD - 1) - word_idx_q] & (32'hFFFF_FFFF << (6'd32 - cur_nbits));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: begin
        if (blk_valid) begin
          if (blk_last)                                state_d = S_CHECK;
          else if (blk_cnt_q == CNT_W'(MAX_BLK - 1))   state_d = S_ERR;
        end
      end
      S_CHECK:   state_d = chk_pass ? ((chk_len == '0) ? S_DONE : S_EMIT) : S_ERR;
      S_EMIT:    if (word_ready && last_word) state_d = S_DONE;
      S_DONE:    state_d = S_COLLECT;
      S_ERR:     state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Datapath updates: block capture, word index, committed length.
  always_comb begin
    blk_cnt_d  = blk_cnt_q;
    blk_d      = blk_q;
    word_idx_d = word_idx_q;
    msg_len_d  = msg_len_q;
    case (state_q)
      S_COLLECT: begin
        if (blk_valid) begin
          for (int k = 0; k < MAX_BLK; k++) begin
            if (blk_cnt_q == CNT_W'(k)) blk_d[MAX_BLK-1-k] = blk_data;
          end
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        word_idx_d = '0;
        if (chk_pass) msg_len_d = chk_len;
      end
      S_EMIT:  if (word_ready) word_idx_d = word_idx_q + WIDX_W'(1);
      S_DONE:  blk_cnt_d = '0;
      S_ERR:   blk_cnt_d = '0;
      default: blk_cnt_d = '0;
    endcase
  end

  // Outputs decoded from state; words only appear in EMIT.
  always_comb begin
    blk_ready  = (state_q == S_COLLECT);
    word_valid = (state_q == S_EMIT);
    word_data  = (state_q == S_EMIT) ? cur_word  : 32'd0;
    word_nbits = (state_q == S_EMIT) ? cur_nbits : 6'd0;
    word_last  = (state_q == S_EMIT) && last_word;
    done       = (state_q == S_DONE);
    err        = (state_q == S_ERR);
    msg_len    = msg_len_q;
  end

  // State and datapath registers; reset discards any buffered blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_COLLECT;
      blk_cnt_q  <= '0;
      blk_q      <= '0;
      word_idx_q <= '0;
      msg_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      blk_cnt_q  <= blk_cnt_d;
      blk_q      <= blk_d;
      word_idx_q <= word_idx_d;
      msg_len_q  <= msg_len_d;
    end
  end

endmodule
